// File: rtl/row_accumulator.sv
// rtl/row_accumulator.sv - per-channel row reduction of signed products into dot-product results
//
// Purpose:
//   One independent reduction lane per channel. Each lane pops a row length
//   from its length FIFO, sums exactly that many sign-extended products from
//   its product FIFO, and holds the result on a valid/ready output tagged
//   with a per-channel row index. The next length is only popped after the
//   result has been accepted.
//
// Ports:
//   clk             - single clock, all state changes on the rising edge
//   rst             - synchronous active-high reset
//   mult            - product FIFO heads, channel i at [i*2*val_bits +: 2*val_bits], signed
//   mult_fifo_empty - per-channel product FIFO empty
//   mult_fifo_read  - per-channel product pop (first-word-fall-through FIFO)
//   len             - row length FIFO heads, channel i at [i*row_len_size +: row_len_size]
//   len_fifo_empty  - per-channel length FIFO empty
//   len_fifo_read   - per-channel length pop
//   res             - row results, channel i at [i*acc_bits +: acc_bits], signed
//   res_row         - row index of the result on res, per channel
//   res_valid       - result valid, per channel
//   res_ready       - downstream accepts result, per channel

module row_accumulator #(
  parameter int channel_num  = 4,
  parameter int val_bits     = 16,
  parameter int row_len_size = 8,
  parameter int acc_bits     = 2 * val_bits + row_len_size,
  parameter int row_id_size  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [2*val_bits*channel_num-1:0]   mult,
  input  logic [channel_num-1:0]              mult_fifo_empty,
  output logic [channel_num-1:0]              mult_fifo_read,
  input  logic [row_len_size*channel_num-1:0] len,
  input  logic [channel_num-1:0]              len_fifo_empty,
  output logic [channel_num-1:0]              len_fifo_read,
  output logic [acc_bits*channel_num-1:0]     res,
  output logic [row_id_size*channel_num-1:0]  res_row,
  output logic [channel_num-1:0]              res_valid,
  input  logic [channel_num-1:0]              res_ready
);

  localparam int prod_bits = 2 * val_bits;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    EMIT = 2'd2
  } state_t;

  for (genvar i = 0; i < channel_num; i++) begin : g_ch

    state_t                   state;
    state_t                   state_next;
    logic [acc_bits-1:0]      acc;
    logic [acc_bits-1:0]      acc_next;
    logic [acc_bits-1:0]      res_q;
    logic [acc_bits-1:0]      res_next;
    logic [row_len_size-1:0]  remaining;
    logic [row_len_size-1:0]  remaining_next;
    logic [row_id_size-1:0]   row_q;
    logic [row_id_size-1:0]   row_next;
    logic signed [prod_bits-1:0] prod;
    logic [row_len_size-1:0]  len_head;
    logic [acc_bits-1:0]      sum;
    logic                     len_pop;
    logic                     mult_pop;

    assign prod     = mult[i*prod_bits +: prod_bits];
    assign len_head = len[i*row_len_size +: row_len_size];

    // Size cast of a signed operand sign-extends the product to the
    // accumulator width; the add then wraps modulo 2^acc_bits.
    assign sum = acc + acc_bits'(prod);

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= IDLE;
        acc       <= '0;
        remaining <= '0;
        res_q     <= '0;
        row_q     <= '0;
      end else begin
        state     <= state_next;
        acc       <= acc_next;
        remaining <= remaining_next;
        res_q     <= res_next;
        row_q     <= row_next;
      end
    end

    always_comb begin
      state_next     = state;
      acc_next       = acc;
      remaining_next = remaining;
      res_next       = res_q;
      row_next       = row_q;
      len_pop        = 1'b0;
      mult_pop       = 1'b0;

      case (state)
        IDLE: begin
          len_pop = ~len_fifo_empty[i];
          if (len_pop) begin
            acc_next       = '0;
            remaining_next = len_head;
            if (len_head == '0) begin
              // Empty row: result is known immediately, skip accumulation.
              res_next   = '0;
              state_next = EMIT;
            end else begin
              state_next = ACC;
            end
          end
        end

        ACC: begin
          mult_pop = ~mult_fifo_empty[i];
          if (mult_pop) begin
            acc_next       = sum;
            remaining_next = remaining - row_len_size'(1);
            if (remaining == row_len_size'(1)) begin
              // Last product of the row goes straight into the result
              // register so EMIT presents the complete sum.
              res_next   = sum;
              state_next = EMIT;
            end
          end
        end

        EMIT: begin
          if (res_ready[i]) begin
            row_next   = row_q + row_id_size'(1);
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // Pops and valid are suppressed while rst is high so that no FIFO entry
    // is consumed and no handshake completes in the reset cycle.
    assign len_fifo_read[i]  = len_pop & ~rst;
    assign mult_fifo_read[i] = mult_pop & ~rst;
    assign res_valid[i]      = (state == EMIT) & ~rst;

    assign res[i*acc_bits +: acc_bits]           = res_q;
    assign res_row[i*row_id_size +: row_id_size] = row_q;

  end

endmodule

// File: tb/tb_row_accumulator.sv
// tb/tb_row_accumulator.sv - self-checking bench for row_accumulator with queue-based FIFO and result model
//
// Purpose:
//   Emulates the product and length FIFOs as queues, predicts each row's
//   dot product and row index with plain integer arithmetic, and checks the
//   DUT outputs, handshake timing and FIFO protocol. A second instance with
//   a 32-bit accumulator checks wrap-around.
//
// Ports: none (top-level bench).

module tb_row_accumulator;

  localparam int CH = 4;
  localparam int VB = 16;
  localparam int LS = 8;
  localparam int AB = 2 * VB + LS;
  localparam int RS = 16;
  localparam int PB = 2 * VB;

  logic               clk = 1'b0;
  logic               rst;
  logic [PB*CH-1:0]   mult;
  logic [CH-1:0]      mult_fifo_empty;
  logic [CH-1:0]      mult_fifo_read;
  logic [LS*CH-1:0]   len;
  logic [CH-1:0]      len_fifo_empty;
  logic [CH-1:0]      len_fifo_read;
  logic [AB*CH-1:0]   res;
  logic [RS*CH-1:0]   res_row;
  logic [CH-1:0]      res_valid;
  logic [CH-1:0]      res_ready;

  logic [31:0]        w_mult;
  logic [0:0]         w_mempty;
  logic [0:0]         w_mread;
  logic [7:0]         w_len;
  logic [0:0]         w_lempty;
  logic [0:0]         w_lread;
  logic [31:0]        w_res;
  logic [15:0]        w_res_row;
  logic [0:0]         w_valid;
  logic [0:0]         w_ready;

  always #5 clk = ~clk;

  row_accumulator u_dut (
    .clk             (clk),
    .rst             (rst),
    .mult            (mult),
    .mult_fifo_empty (mult_fifo_empty),
    .mult_fifo_read  (mult_fifo_read),
    .len             (len),
    .len_fifo_empty  (len_fifo_empty),
    .len_fifo_read   (len_fifo_read),
    .res             (res),
    .res_row         (res_row),
    .res_valid       (res_valid),
    .res_ready       (res_ready)
  );

  row_accumulator #(.channel_num(1), .acc_bits(32)) u_wrap (
    .clk             (clk),
    .rst             (rst),
    .mult            (w_mult),
    .mult_fifo_empty (w_mempty),
    .mult_fifo_read  (w_mread),
    .len             (w_len),
    .len_fifo_empty  (w_lempty),
    .len_fifo_read   (w_lread),
    .res             (w_res),
    .res_row         (w_res_row),
    .res_valid       (w_valid),
    .res_ready       (w_ready)
  );

  // Reference model state.
  logic [PB-1:0] mq [CH][$];
  logic [LS-1:0] lq [CH][$];
  logic [AB-1:0] exp_res [CH][$];
  longint        run_sum [CH];
  int            exp_row [CH];

  // Stimulus controls.
  int  stall_pct;
  int  ready_low_pct;
  bit  force_m [CH];
  bit  hold_low [CH];
  bit  lat_on;
  bit  post_rst;

  // Observation history.
  int            cyc;
  int            pop_cyc [CH];
  int            pop_len [CH];
  int            bubble_at [CH];
  int            mpop_cnt [CH];
  bit            prev_valid [CH];
  bit            prev_ready [CH];
  logic [AB-1:0] prev_res [CH];
  logic [RS-1:0] prev_row [CH];
  int            w_seen;

  int n_checks;
  int n_pass;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_len(input int ch, input int l);
    lq[ch].push_back(LS'(l));
    run_sum[ch] = 0;
  endtask

  task automatic push_prod(input int ch, input int p);
    mq[ch].push_back(PB'(p));
    run_sum[ch] = run_sum[ch] + longint'(p);
  endtask

  task automatic end_row(input int ch);
    logic [63:0] t;
    t = run_sum[ch];
    exp_res[ch].push_back(t[AB-1:0]);
  endtask

  task automatic push_rand_row(input int ch, input int lmin, input int lmax);
    int l;
    l = $urandom_range(lmax, lmin);
    push_len(ch, l);
    for (int k = 0; k < l; k++) push_prod(ch, int'($urandom));
    end_row(ch);
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int ch = 0; ch < CH; ch++) n += mq[ch].size() + lq[ch].size() + exp_res[ch].size();
    return n;
  endfunction

  task automatic drive_inputs();
    bit me;
    bit le;
    for (int ch = 0; ch < CH; ch++) begin
      me = (mq[ch].size() == 0) || force_m[ch] || ($urandom_range(99, 0) < stall_pct);
      le = (lq[ch].size() == 0) || ($urandom_range(99, 0) < stall_pct);
      mult_fifo_empty[ch] = me;
      len_fifo_empty[ch]  = le;
      if (me) mult[ch*PB +: PB] = PB'($urandom);
      else    mult[ch*PB +: PB] = mq[ch][0];
      if (le) len[ch*LS +: LS] = LS'($urandom);
      else    len[ch*LS +: LS] = lq[ch][0];
      res_ready[ch] = hold_low[ch] ? 1'b0 : ($urandom_range(99, 0) >= ready_low_pct);
    end
  endtask

  task automatic tick();
    logic          mr, lr, v, r;
    logic [AB-1:0] rv;
    logic [RS-1:0] rr;
    bit            do_m [CH];
    bit            do_l [CH];
    int            exp_lat;
    drive_inputs();
    #2;
    for (int ch = 0; ch < CH; ch++) begin
      mr = mult_fifo_read[ch];
      lr = len_fifo_read[ch];
      v  = res_valid[ch];
      r  = res_ready[ch];
      rv = res[ch*AB +: AB];
      rr = res_row[ch*RS +: RS];
      if (rst) begin
        chk("rst_mult_read", mr, 0);
        chk("rst_len_read", lr, 0);
      end else begin
        if (post_rst) begin
          chk("post_rst_valid", v, 0);
          chk("post_rst_res", rv, 0);
          chk("post_rst_row", rr, 0);
        end
        if (mr) chk("mult_read_when_empty", mult_fifo_empty[ch], 0);
        if (lr) chk("len_read_when_empty", len_fifo_empty[ch], 0);
        if (v) chk("read_during_emit", {mr, lr}, 0);
        if (prev_valid[ch] && !prev_ready[ch]) begin
          chk("valid_held", v, 1);
          chk("res_stable", rv, prev_res[ch]);
          chk("row_stable", rr, prev_row[ch]);
        end
        if (lat_on && v && !prev_valid[ch]) begin
          exp_lat = (pop_len[ch] == 0) ? 1 : pop_len[ch] + 1;
          chk("result_latency", 64'(cyc - pop_cyc[ch]), 64'(exp_lat));
        end
        if (lat_on && cyc == bubble_at[ch] && lq[ch].size() > 0)
          chk("len_pop_after_accept", lr, 1);
        if (v && r) begin
          if (exp_res[ch].size() == 0) begin
            chk("unexpected_result", 64'(exp_res[ch].size()), 1);
          end else begin
            chk($sformatf("res_ch%0d", ch), rv, exp_res[ch][0]);
            chk($sformatf("row_ch%0d", ch), rr, 64'(exp_row[ch] % 65536));
            void'(exp_res[ch].pop_front());
            exp_row[ch]++;
            bubble_at[ch] = cyc + 1;
          end
        end
        if (lr && lq[ch].size() > 0) begin
          pop_cyc[ch]  = cyc;
          pop_len[ch]  = int'(lq[ch][0]);
          mpop_cnt[ch] = 0;
        end
        if (mr) mpop_cnt[ch]++;
      end
      prev_valid[ch] = v && !rst;
      prev_ready[ch] = r;
      prev_res[ch]   = rv;
      prev_row[ch]   = rr;
      do_m[ch] = mr;
      do_l[ch] = lr;
    end
    if (!rst) post_rst = 1'b0;
    if (!rst && w_valid[0]) begin
      chk("wrap_res_acc32", w_res, 64'h0000_0000_FFFF_FFFE);
      w_seen++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int ch = 0; ch < CH; ch++) begin
      if (do_m[ch] && mq[ch].size() > 0) void'(mq[ch].pop_front());
      if (do_l[ch] && lq[ch].size() > 0) void'(lq[ch].pop_front());
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (pending() == 0) break;
      tick();
    end
    chk("drain_pending", 64'(pending()), 0);
  endtask

  task automatic clear_model();
    for (int ch = 0; ch < CH; ch++) begin
      mq[ch].delete();
      lq[ch].delete();
      exp_res[ch].delete();
      run_sum[ch]    = 0;
      exp_row[ch]    = 0;
      prev_valid[ch] = 1'b0;
      prev_ready[ch] = 1'b0;
      bubble_at[ch]  = -10;
      mpop_cnt[ch]   = -100;
      pop_cyc[ch]    = 0;
      pop_len[ch]    = 0;
      force_m[ch]    = 1'b0;
      hold_low[ch]   = 1'b0;
    end
  endtask

  initial begin
    int k;
    n_checks = 0; n_pass = 0; n_fail = 0;
    cyc = 0; w_seen = 0;
    stall_pct = 0; ready_low_pct = 0; lat_on = 1'b0; post_rst = 1'b0;
    w_mult = 32'h7FFF_FFFF; w_len = 8'd2; w_mempty = 1'b0; w_lempty = 1'b0; w_ready = 1'b1;
    mult = '0; len = '0; mult_fifo_empty = '1; len_fifo_empty = '1; res_ready = '0;
    clear_model();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Rows queued before reset release: reads must stay low during reset.
    push_len(0, 3); push_prod(0, 2); push_prod(0, 3); push_prod(0, -1); end_row(0);
    push_rand_row(0, 1, 4);
    push_len(1, 0); end_row(1);
    push_len(1, 2); push_prod(1, 5); push_prod(1, 5); end_row(1);
    push_rand_row(2, 1, 4);
    push_rand_row(3, 0, 3);
    tick();
    tick();
    rst = 1'b0;
    post_rst = 1'b1;

    // Directed rows with no stalls: exact latency and one-cycle bubble.
    lat_on = 1'b1;
    drain(200);

    // Product FIFO stalls 3 cycles after the second pop of a 4-long row.
    lat_on = 1'b0;
    push_len(0, 4);
    for (int i = 0; i < 4; i++) push_prod(0, 1);
    end_row(0);
    mpop_cnt[0] = -100;
    k = 0;
    while (mpop_cnt[0] != 2 && k < 50) begin tick(); k++; end
    chk("stall_setup", 64'(mpop_cnt[0]), 2);
    force_m[0] = 1'b1;
    repeat (3) tick();
    chk("stall_acc_hold", 64'(mpop_cnt[0]), 2);
    force_m[0] = 1'b0;
    drain(100);

    // Result held while res_ready is low, next length already queued.
    push_rand_row(0, 2, 2);
    push_rand_row(0, 1, 1);
    hold_low[0] = 1'b1;
    k = 0;
    while (!prev_valid[0] && k < 50) begin tick(); k++; end
    chk("hold_setup_valid", prev_valid[0], 1);
    repeat (5) tick();
    chk("hold_len_not_popped", 64'(lq[0].size()), 1);
    hold_low[0] = 1'b0;
    lat_on = 1'b1;
    drain(100);

    // Randomized rows with random FIFO stalls and backpressure.
    lat_on = 1'b0;
    stall_pct = 25;
    ready_low_pct = 30;
    push_len(1, 2); push_prod(1, 32'h7FFF_FFFF); push_prod(1, 32'h7FFF_FFFF); end_row(1);
    for (int ch = 0; ch < CH; ch++)
      for (int n = 0; n < 40; n++) push_rand_row(ch, 0, 7);
    drain(5000);

    // Reset mid-row on ch2 while ch3 is busy.
    stall_pct = 0;
    ready_low_pct = 0;
    push_rand_row(2, 5, 5);
    for (int n = 0; n < 4; n++) push_rand_row(3, 1, 6);
    mpop_cnt[2] = -100;
    k = 0;
    while (mpop_cnt[2] != 2 && k < 60) begin tick(); k++; end
    chk("midrow_setup", 64'(mpop_cnt[2]), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    post_rst = 1'b1;
    lat_on = 1'b1;
    for (int ch = 0; ch < CH; ch++)
      for (int n = 0; n < 5; n++) push_rand_row(ch, 0, 5);
    drain(400);

    chk("wrap_instance_seen", 64'(w_seen > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/row_accumulator.md
# row_accumulator

Per-channel row reduction stage sitting directly downstream of the multiplier channels in the SpMV datapath. For each channel it pops a row length from the length fetcher FIFO, sums exactly that many signed products from the channel's mult FIFO, and presents one dot-product result per row on a valid/ready output with a per-channel row index. Channels are fully independent.

## Interface
- channel_num, 4: number of independent channels.
- val_bits, 16: matrix/vector value width; products are 2*val_bits wide.
- row_len_size, 8: row length width.
- acc_bits, 2*val_bits+row_len_size: accumulator/result width.
- row_id_size, 16: per-channel row counter width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mult  in  2*val_bits*channel_num  product FIFO heads; channel i at [i*2*val_bits +: 2*val_bits], signed.
- mult_fifo_empty  in  channel_num  per-channel product FIFO empty.
- mult_fifo_read  out  channel_num  per-channel product pop.
- len  in  row_len_size*channel_num  row length FIFO heads, unsigned.
- len_fifo_empty  in  channel_num  per-channel length FIFO empty.
- len_fifo_read  out  channel_num  per-channel length pop.
- res  out  acc_bits*channel_num  row results, signed.
- res_row  out  row_id_size*channel_num  row index of the result on res.
- res_valid  out  channel_num  result valid.
- res_ready  in  channel_num  downstream accepts result.

## Operation
- Input FIFOs are first-word-fall-through: head valid whenever empty=0; read=1 pops at that clock edge. Block never asserts read while the matching empty=1.
- Per-channel FSM, states IDLE, ACC, EMIT:
  - IDLE: len_fifo_read = ~len_fifo_empty. On pop: acc<=0, remaining<=len. len==0 -> EMIT with res=0; else -> ACC.
  - ACC: mult_fifo_read = ~mult_fifo_empty. Each pop: acc<=acc+sext(product), remaining<=remaining-1. Pop with remaining==1 -> EMIT with res=acc+sext(product). No pop -> hold.
  - EMIT: res_valid=1, res/res_row stable. On res_ready: res_row<=res_row+1, -> IDLE. No FIFO reads in EMIT.
- Read outputs are combinational from state and empty; no other inputs.
- Arithmetic: product sign-extended from 2*val_bits to acc_bits; addition wraps mod 2^acc_bits, no saturation or overflow flag.
- res_row wraps from 2^row_id_size-1 to 0.
- Products beyond the current row length are never consumed until the next length is popped.

## Timing
- Reset (synchronous): all channels IDLE; acc, remaining, res, res_row = 0; res_valid = 0; mult_fifo_read = len_fifo_read = 0 in the reset cycle.
- Length pop at cycle T; first product pop earliest T+1; with no stalls res_valid rises at T+1+L for L>0, at T+1 for L=0.
- Handshake completes on the edge where res_valid&res_ready; next len pop earliest the following cycle (one-cycle IDLE bubble per row). Steady-state throughput L+2 cycles per row.
- Mult FIFO empty in ACC: stall, acc and remaining unchanged, no timeout.
- res_ready low: remain in EMIT indefinitely; input FIFOs untouched.
- rst mid-row: partial sum discarded, already-popped entries are lost; upstream FIFO realignment is the top level's responsibility.
- res_ready ignored when res_valid=0.

## Test plan
- Row L=3, products 2, 3, -1 on ch0, FIFOs always non-empty, res_ready=1 -> len pop T, mult pops T+1..T+3, res_valid at T+4 with res=4, res_row=0; next row gets res_row=1.
- L=0 on ch1 -> res_valid at T+1, res=0, no mult_fifo_read asserted; following L=2 row (5, 5) -> res=10.
- L=4 products 1 each, mult_fifo_empty high for 3 cycles after second pop -> result 4 at T+8, acc holds during stall, mult_fifo_read low while empty.
- res_ready low for 5 cycles on valid result with next length queued -> res stable, len_fifo_read stays 0 until one cycle after accept.
- L=2 products 0x7FFF_FFFF each with acc_bits=32 override -> res=0xFFFF_FFFE (wrap); with default acc_bits=40 -> 0x00_FFFF_FFFE.
- rst asserted after 2 of 5 products on ch2 while ch3 runs -> all channels IDLE, res_valid=0, res_row=0 next cycle; rows after reset sum from 0.
